// File: rtl/mips_pkg.sv
// Shared encodings, the ID/EX shadow-slot layout and the hazard match helper
// used by the hazard/forwarding control block.
package mips_pkg;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] dst;
        logic       regWrite;
        logic       memRead;
        logic [4:0] rs;
        logic [4:0] rt;
    } shadow_slot_t;

    localparam int SLOT_W = $bits(shadow_slot_t);
    localparam shadow_slot_t SLOT_BUBBLE = 17'd0;

    // $0 is hardwired, so a write to it can never be a producer.
    function automatic logic slot_match(input logic [4:0] dst, input logic reg_write,
                                        input logic [4:0] r);
        return reg_write && (dst != REG_ZERO) && (dst == r);
    endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of destination/control info for the ID/EX, EX/MEM and MEM/WB
// stages; a bubble enters ID/EX whenever control select is low.
module hazard_shadow_pipe
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SLOT_W-1:0] i_id_slot,
    input  logic              i_control_sel,
    output logic [SLOT_W-1:0] o_s1,
    output logic [4:0]        o_s2_dst,
    output logic              o_s2_reg_write,
    output logic [4:0]        o_s3_dst,
    output logic              o_s3_reg_write
);

    shadow_slot_t r_s1;
    logic [4:0]   r_s2_dst;
    logic         r_s2_reg_write;
    logic [4:0]   r_s3_dst;
    logic         r_s3_reg_write;

    // Advance the shadow slots one stage per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1           <= SLOT_BUBBLE;
            r_s2_dst       <= REG_ZERO;
            r_s2_reg_write <= 1'b0;
            r_s3_dst       <= REG_ZERO;
            r_s3_reg_write <= 1'b0;
        end else begin
            r_s3_dst       <= r_s2_dst;
            r_s3_reg_write <= r_s2_reg_write;
            r_s2_dst       <= r_s1.dst;
            r_s2_reg_write <= r_s1.regWrite;
            if (i_control_sel) begin
                r_s1 <= shadow_slot_t'(i_id_slot);
            end else begin
                r_s1 <= SLOT_BUBBLE;
            end
        end
    end

    assign o_s1           = r_s1;
    assign o_s2_dst       = r_s2_dst;
    assign o_s2_reg_write = r_s2_reg_write;
    assign o_s3_dst       = r_s3_dst;
    assign o_s3_reg_write = r_s3_reg_write;

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard control: operand forwarding, load-use and branch-operand
// stalls, branch/jump redirection and saturating debug event counters.
module hazard_forward_unit
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic [4:0]       idRd,
    input  logic             idUsesRs,
    input  logic             idUsesRt,
    input  logic             idRegWrite,
    input  logic             idRegDst,
    input  logic             idMemRead,
    input  logic             idBranch,
    input  logic             idJump,
    input  logic             equal,
    output logic [1:0]       pcSrc,
    output logic [1:0]       aSel,
    output logic [1:0]       bSel,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifFlush,
    output logic             controlSel,
    output logic             stall,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    shadow_slot_t     w_id_slot;
    shadow_slot_t     w_s1;
    logic [SLOT_W-1:0] w_s1_bits;
    logic [4:0]       w_s2_dst;
    logic             w_s2_reg_write;
    logic [4:0]       w_s3_dst;
    logic             w_s3_reg_write;
    logic             w_load_stall;
    logic             w_br_stall;
    logic             w_stall;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Pack the ID instruction's destination and control into slot form.
    always_comb begin
        w_id_slot          = SLOT_BUBBLE;
        w_id_slot.dst      = idRegDst ? idRd : idRt;
        w_id_slot.regWrite = idRegWrite;
        w_id_slot.memRead  = idMemRead;
        w_id_slot.rs       = idRs;
        w_id_slot.rt       = idRt;
    end

    hazard_shadow_pipe u_shadow (
        .clk            (clk),
        .rst            (rst),
        .i_id_slot      (w_id_slot),
        .i_control_sel  (controlSel),
        .o_s1           (w_s1_bits),
        .o_s2_dst       (w_s2_dst),
        .o_s2_reg_write (w_s2_reg_write),
        .o_s3_dst       (w_s3_dst),
        .o_s3_reg_write (w_s3_reg_write)
    );

    assign w_s1 = shadow_slot_t'(w_s1_bits);

    // Forwarding selects and stall detection from the shadow slots.
    always_comb begin
        aSel         = FWD_REG;
        bSel         = FWD_REG;
        w_load_stall = 1'b0;
        w_br_stall   = 1'b0;
        if (rst) begin
            aSel = FWD_REG;
        end else begin
            if (slot_match(w_s2_dst, w_s2_reg_write, w_s1.rs)) begin
                aSel = FWD_MEM;
            end else if (slot_match(w_s3_dst, w_s3_reg_write, w_s1.rs)) begin
                aSel = FWD_WB;
            end else begin
                aSel = FWD_REG;
            end
            if (slot_match(w_s2_dst, w_s2_reg_write, w_s1.rt)) begin
                bSel = FWD_MEM;
            end else if (slot_match(w_s3_dst, w_s3_reg_write, w_s1.rt)) begin
                bSel = FWD_WB;
            end else begin
                bSel = FWD_REG;
            end
            w_load_stall = w_s1.memRead &&
                ((idUsesRs && slot_match(w_s1.dst, w_s1.regWrite, idRs)) ||
                 (idUsesRt && slot_match(w_s1.dst, w_s1.regWrite, idRt)));
            // The ID comparator has no bypass: wait until every producer has retired.
            w_br_stall = idBranch && (
                (idUsesRs && (slot_match(w_s1.dst, w_s1.regWrite, idRs) ||
                              slot_match(w_s2_dst, w_s2_reg_write, idRs) ||
                              slot_match(w_s3_dst, w_s3_reg_write, idRs))) ||
                (idUsesRt && (slot_match(w_s1.dst, w_s1.regWrite, idRt) ||
                              slot_match(w_s2_dst, w_s2_reg_write, idRt) ||
                              slot_match(w_s3_dst, w_s3_reg_write, idRt))));
        end
    end

    assign w_stall = w_load_stall | w_br_stall;

    // Stall/redirect control with stall > jump > branch priority.
    always_comb begin
        pcSrc      = PC_INC;
        ifFlush    = 1'b0;
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        controlSel = 1'b0;
        stall      = 1'b0;
        if (rst) begin
            controlSel = 1'b0;
        end else if (w_stall) begin
            stall     = 1'b1;
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
        end else begin
            controlSel = 1'b1;
            if (idJump) begin
                pcSrc   = PC_JUMP;
                ifFlush = 1'b1;
            end else if (idBranch && equal) begin
                pcSrc   = PC_BRANCH;
                ifFlush = 1'b1;
            end else begin
                pcSrc   = PC_INC;
                ifFlush = 1'b0;
            end
        end
    end

    // Saturating debug counters of stall cycles and flush events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (ifFlush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stallCount = r_stall_cnt;
    assign flushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: directed pipeline scenarios plus randomized instruction
// streams compared every cycle against an instruction-level pipeline model.
module tb_hazard_forward_unit;

    localparam int TB_CNT_W = 4;
    localparam int MAXC     = (1 << TB_CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] idRs, idRt, idRd;
    logic       idUsesRs, idUsesRt, idRegWrite, idRegDst, idMemRead;
    logic       idBranch, idJump, equal;
    logic [1:0] pcSrc, aSel, bSel;
    logic       pcWrite, ifidWrite, ifFlush, controlSel, stall;
    logic [TB_CNT_W-1:0] stallCount, flushCount;

    hazard_forward_unit #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idRegWrite(idRegWrite),
        .idRegDst(idRegDst), .idMemRead(idMemRead), .idBranch(idBranch),
        .idJump(idJump), .equal(equal), .pcSrc(pcSrc), .aSel(aSel), .bSel(bSel),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifFlush(ifFlush),
        .controlSel(controlSel), .stall(stall), .stallCount(stallCount),
        .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: instructions in flight, index 1 = EX, 2 = MEM, 3 = WB.
    bit [4:0] m_dst [1:3];
    bit [4:0] m_rs  [1:3];
    bit [4:0] m_rt  [1:3];
    bit       m_wr  [1:3];
    bit       m_ld  [1:3];
    bit       m_urs [1:3];
    bit       m_urt [1:3];
    int       m_sc = 0;
    int       m_fc = 0;

    typedef struct {
        int a, b, pc;
        bit stall, flush, pcw, ifw, cs;
    } exp_t;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit writes(input int k, input bit [4:0] r);
        return m_wr[k] && (m_dst[k] != 5'd0) && (m_dst[k] == r);
    endfunction

    function automatic int fwd(input bit [4:0] r);
        if (writes(2, r)) return 1;
        if (writes(3, r)) return 2;
        return 0;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit ld, br;
        e.a = 0; e.b = 0; e.pc = 0; e.stall = 0; e.flush = 0;
        e.pcw = 1; e.ifw = 1; e.cs = 0;
        if (rst) return e;
        ld = m_ld[1] && ((idUsesRs && writes(1, idRs)) || (idUsesRt && writes(1, idRt)));
        br = 0;
        for (int k = 1; k <= 3; k++)
            br = br || (idUsesRs && writes(k, idRs)) || (idUsesRt && writes(k, idRt));
        br = br && idBranch;
        e.a = fwd(m_rs[1]);
        e.b = fwd(m_rt[1]);
        e.stall = ld || br;
        e.pcw = !e.stall; e.ifw = !e.stall; e.cs = !e.stall;
        if (e.stall)                 e.pc = 0;
        else if (idJump)             e.pc = 2;
        else if (idBranch && equal)  e.pc = 1;
        else                         e.pc = 0;
        e.flush = (e.pc != 0);
        return e;
    endfunction

    // Model state advance on every clock edge; cleared asynchronously by reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int k = 1; k <= 3; k++) begin
                    m_dst[k] = 0; m_rs[k] = 0; m_rt[k] = 0; m_wr[k] = 0;
                    m_ld[k] = 0; m_urs[k] = 0; m_urt[k] = 0;
                end
                m_sc = 0; m_fc = 0;
            end else begin
                e = predict();
                if (e.stall && m_sc < MAXC) m_sc = m_sc + 1;
                if (e.flush && m_fc < MAXC) m_fc = m_fc + 1;
                for (int k = 3; k >= 2; k--) begin
                    m_dst[k] = m_dst[k-1]; m_rs[k] = m_rs[k-1]; m_rt[k] = m_rt[k-1];
                    m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1];
                    m_urs[k] = m_urs[k-1]; m_urt[k] = m_urt[k-1];
                end
                if (e.cs) begin
                    m_dst[1] = idRegDst ? idRd : idRt;
                    m_rs[1] = idRs; m_rt[1] = idRt; m_wr[1] = idRegWrite;
                    m_ld[1] = idMemRead; m_urs[1] = idUsesRs; m_urt[1] = idUsesRt;
                end else begin
                    m_dst[1] = 0; m_rs[1] = 0; m_rt[1] = 0; m_wr[1] = 0;
                    m_ld[1] = 0; m_urs[1] = 0; m_urt[1] = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            e = predict();
            cmp("aSel", aSel, e.a);
            cmp("bSel", bSel, e.b);
            cmp("pcSrc", pcSrc, e.pc);
            cmp("stall", stall, e.stall);
            cmp("ifFlush", ifFlush, e.flush);
            cmp("pcWrite", pcWrite, e.pcw);
            cmp("ifidWrite", ifidWrite, e.ifw);
            cmp("controlSel", controlSel, e.cs);
            cmp("stallCount", stallCount, m_sc);
            cmp("flushCount", flushCount, m_fc);
            cmp("inv_load_fwd",
                int'(!rst && ((aSel == 2'd1 && m_ld[2] && m_urs[1]) ||
                              (bSel == 2'd1 && m_ld[2] && m_urt[1]))), 0);
        end
    end

    task automatic set_nop();
        idRs = 0; idRt = 0; idRd = 0; idUsesRs = 0; idUsesRt = 0; idRegWrite = 0;
        idRegDst = 0; idMemRead = 0; idBranch = 0; idJump = 0; equal = 0;
    endtask

    task automatic set_r(input int rs, input int rt, input int rd);
        set_nop();
        idRs = 5'(rs); idRt = 5'(rt); idRd = 5'(rd);
        idUsesRs = 1; idUsesRt = 1; idRegWrite = 1; idRegDst = 1;
    endtask

    task automatic set_lw(input int base, input int rt);
        set_nop();
        idRs = 5'(base); idRt = 5'(rt); idUsesRs = 1; idRegWrite = 1; idMemRead = 1;
    endtask

    task automatic set_beq(input int rs, input int rt, input bit eq);
        set_nop();
        idRs = 5'(rs); idRt = 5'(rt); idUsesRs = 1; idUsesRt = 1; idBranch = 1; equal = eq;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        set_nop();
        next();
        rst = 0;
    endtask

    bit hold;
    int kind;

    initial begin
        rst = 1;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        to_neg();
        cmp("rst_pcWrite", pcWrite, 1);
        cmp("rst_controlSel", controlSel, 0);
        cmp("rst_stall", stall, 0);
        next();
        rst = 0;

        // Back-to-back ALU dependencies.
        set_r(1, 2, 3); to_neg(); next();
        set_r(3, 5, 4); to_neg(); next();
        set_r(3, 3, 6); to_neg();
        cmp("b2b_sub_a", aSel, 1); cmp("b2b_sub_b", bSel, 0); cmp("b2b_stall1", stall, 0);
        next();
        set_nop(); to_neg();
        cmp("b2b_or_a", aSel, 2); cmp("b2b_or_b", bSel, 2); cmp("b2b_stall2", stall, 0);
        next();

        // Load-use.
        do_reset();
        set_lw(1, 2); to_neg(); next();
        set_r(2, 1, 4); to_neg();
        cmp("lu_stall", stall, 1); cmp("lu_pcWrite", pcWrite, 0);
        cmp("lu_ifidWrite", ifidWrite, 0); cmp("lu_controlSel", controlSel, 0);
        next();
        to_neg();
        cmp("lu_release", stall, 0); cmp("lu_stallCount", stallCount, 1);
        next();
        set_nop(); to_neg();
        cmp("lu_add_a", aSel, 2); cmp("lu_add_b", bSel, 0);
        next();

        // Writes to $0 never forward or stall.
        do_reset();
        set_nop(); idRs = 1; idUsesRs = 1; idRegWrite = 1; to_neg(); next();
        set_r(0, 0, 4); to_neg(); cmp("z_stall", stall, 0); next();
        set_nop(); to_neg();
        cmp("z_a", aSel, 0); cmp("z_b", bSel, 0);
        next();

        // Branch on a freshly produced register.
        do_reset();
        set_r(1, 2, 3); to_neg(); next();
        set_beq(3, 4, 1);
        for (int i = 0; i < 3; i++) begin
            to_neg();
            cmp("br_stall", stall, 1); cmp("br_pcSrc_hold", pcSrc, 0);
            next();
        end
        to_neg();
        cmp("br_release", stall, 0); cmp("br_pcSrc", pcSrc, 1); cmp("br_flush", ifFlush, 1);
        next();
        set_nop(); to_neg();
        cmp("br_flushCount", flushCount, 1); cmp("br_stallCount", stallCount, 3);
        next();

        // Jump with a live load ahead of it.
        do_reset();
        set_lw(1, 2); to_neg(); next();
        set_nop(); idJump = 1; idRs = 2; to_neg();
        cmp("j_pcSrc", pcSrc, 2); cmp("j_flush", ifFlush, 1); cmp("j_stall", stall, 0);
        next();
        set_nop(); to_neg(); next();

        // Reset in the middle of a branch stall.
        do_reset();
        set_r(1, 2, 3); to_neg(); next();
        set_beq(3, 4, 1); to_neg(); cmp("rm_stall1", stall, 1); next();
        #3;
        rst = 1;
        #1;
        cmp("rm_stall", stall, 0); cmp("rm_pcWrite", pcWrite, 1);
        cmp("rm_controlSel", controlSel, 0); cmp("rm_stallCount", stallCount, 0);
        cmp("rm_flushCount", flushCount, 0);
        next();
        rst = 0;
        set_beq(7, 8, 1); to_neg();
        cmp("rm_br_stall", stall, 0); cmp("rm_br_pcSrc", pcSrc, 1); cmp("rm_br_flush", ifFlush, 1);
        next();

        // Randomized instruction stream, ID held while the model says stall.
        do_reset();
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (rst) rst = 0;
            if ($urandom_range(0, 149) == 0) rst = 1;
            if (!hold || rst) begin
                kind = $urandom_range(0, 9);
                set_nop();
                idRs = 5'($urandom_range(0, 7));
                idRt = 5'($urandom_range(0, 7));
                idRd = 5'($urandom_range(0, 7));
                equal = 1'($urandom_range(0, 1));
                case (kind)
                    0, 1, 2: begin idUsesRs = 1; idUsesRt = 1; idRegWrite = 1; idRegDst = 1; end
                    3:       begin idUsesRs = 1; idRegWrite = 1; end
                    4, 5:    begin idUsesRs = 1; idRegWrite = 1; idMemRead = 1; end
                    6:       begin idUsesRs = 1; idUsesRt = 1; end
                    7:       begin idUsesRs = 1; idUsesRt = 1; idBranch = 1; end
                    8:       begin idJump = 1; end
                    default: begin idUsesRs = 1; idUsesRt = 1; idBranch = 1; idJump = 1; end
                endcase
            end
            to_neg();
            hold = predict().stall;
            next();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Control-side counterpart of the pipeline datapath. It drives the datapath's pcSrc, aSel, bSel, pcWrite, ifidWrite, ifFlush, stall and controlSel inputs, and consumes its equal output.
- Keeps an internal shadow pipeline of destination and control info for the ID/EX, EX/MEM and MEM/WB stages.
- From that shadow state it resolves ALU operand forwarding, load-use and branch-operand stalls, and branch/jump redirection.
- Also keeps saturating stall and flush event counters for debug.

Parameters:
CNT_W, 16, width of the stall and flush event counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
idRs  in  5  rs field of the instruction in ID.
idRt  in  5  rt field of the instruction in ID.
idRd  in  5  rd field of the instruction in ID.
idUsesRs  in  1  ID instruction reads rs.
idUsesRt  in  1  ID instruction reads rt (R-type, beq, sw).
idRegWrite  in  1  main-controller regWrite for the ID instruction.
idRegDst  in  1  1 = destination is rd, 0 = destination is rt.
idMemRead  in  1  ID instruction is a load.
idBranch  in  1  ID instruction is beq.
idJump  in  1  ID instruction is j.
equal  in  1  ID-stage register comparator result from the datapath.
pcSrc  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
aSel  out  2  EX operand A source: 0 = register, 1 = EX/MEM, 2 = MEM/WB.
bSel  out  2  EX operand B source, same encoding as aSel.
pcWrite  out  1  PC load enable.
ifidWrite  out  1  IF/ID load enable.
ifFlush  out  1  clear IF/ID to a nop.
controlSel  out  1  0 = inject a bubble into ID/EX.
stall  out  1  a stall is asserted this cycle.
stallCount  out  CNT_W  number of stall cycles, saturating.
flushCount  out  CNT_W  number of flush events, saturating.

Behaviour:
- Shadow slots:
  - S1 (ID/EX) holds {dst, regWrite, memRead, rs, rt}.
  - S2 (EX/MEM) holds {dst, regWrite, memRead}.
  - S3 (MEM/WB) holds {dst, regWrite}.
  - dst = idRegDst ? idRd : idRt.
- Slot update, every edge: S3 <= S2, S2 <= S1.
  - S1 <= ID info when controlSel = 1.
  - S1 <= all-zero bubble when controlSel = 0.
- Hazard match: a slot matches register r only when slot.regWrite = 1, slot.dst != 0 and slot.dst == r. Register $0 never forwards or stalls.
- Forwarding (combinational from slots, zero latency):
  - aSel = 1 if S2 matches S1.rs; else 2 if S3 matches S1.rs; else 0. EX/MEM has priority.
  - bSel: same rule applied to S1.rt, applied regardless of aluSel so store data is forwarded.
- Load-use stall (loadStall): S1.memRead and S1 matches (idUsesRs and idRs) or (idUsesRt and idRt).
- Branch stall (brStall): idBranch and any of S1, S2, S3 matches a used source (idRs/idRt).
  - The comparator in ID has no forwarding, and the register file is written at the edge ending WB.
  - Worst case is 3 stall cycles.
- stall = loadStall | brStall. While stall = 1:
  - pcWrite = 0, ifidWrite = 0, controlSel = 0.
  - pcSrc = 0, ifFlush = 0.
- Redirect, only when stall = 0:
  - idJump: pcSrc = 2, ifFlush = 1.
  - Otherwise idBranch and equal: pcSrc = 1, ifFlush = 1.
  - Otherwise pcSrc = 0, ifFlush = 0.
  - pcWrite, ifidWrite and controlSel are 1 whenever stall = 0.
- Priority: stall > jump > branch. idJump and idBranch both high is illegal; jump wins.
- Counters:
  - stallCount increments on each edge where stall = 1.
  - flushCount increments on each edge where ifFlush = 1.
  - Both hold at all-ones; no wrap.
- Invariant: S2.memRead and a forward from S2 are never true together; the load-use stall guarantees it, and the bench asserts it.
- Reset (rst high, asynchronous, effective immediately and mid-stall included):
  - All slots and counters cleared.
  - Outputs forced to pcSrc = 0, aSel = 0, bSel = 0, ifFlush = 0, stall = 0, pcWrite = 1, ifidWrite = 1, controlSel = 0, counters = 0.
  - First edge after deassertion: normal operation, with empty slots.

Decomposition:
- mips_pkg holds:
  - pcSrc encodings PC_INC/PC_BRANCH/PC_JUMP;
  - forward encodings FWD_REG/FWD_MEM/FWD_WB;
  - packed struct shadow_slot_t {dst, regWrite, memRead, rs, rt};
  - REG_ZERO = 5'd0.
- One sub-module, hazard_shadow_pipe: the three slot registers with bubble insertion and async reset.
- Forwarding, stall, redirect and counter logic stay in the top.

Test Plan:
- Back-to-back dependency: add $3,$1,$2; sub $4,$3,$5; or $6,$3,$3 -> sub in EX: aSel=1, bSel=0. or in EX: aSel=2, bSel=2. stall never asserted.
- Load-use: lw $2,0($1); add $4,$2,$1 -> one cycle with stall=1, pcWrite=0, ifidWrite=0, controlSel=0, stallCount=1. Next cycle add in EX with aSel=2.
- $0 destination: addi $0,$1,5; add $4,$0,$0 -> aSel=0, bSel=0, stall=0.
- Dependent branch: add $3,$1,$2; beq $3,$4,L with equal=1 when released -> stall=1 for 3 cycles, then pcSrc=1, ifFlush=1, flushCount=1.
- Jump with a live load in S1: idJump=1, idUsesRs=0 -> pcSrc=2, ifFlush=1, stall=0 in the same cycle.
- Reset mid-stall: assert rst during the second branch-stall cycle -> stall=0, pcWrite=1, controlSel=0, counters 0 immediately, without waiting for a clock edge. After release, an independent beq with equal=1 redirects with no stall.
